// File: rtl/task_bus_pkg.sv
// -----------------------------------------------------------------------------
// task_bus_pkg
// Shared definitions for the 16-bit task command bus and the per-task sorter
// words: opcode values, command-word field positions, sorter-word layout and
// the dispatcher FSM state encoding.
//
// Command word : {4'b0, id[3:0], opcode[3:0], arg[3:0]}
// Sorter word  : {id[3:0], prio[3:0]}, all-zero = task not ready
// -----------------------------------------------------------------------------
package task_bus_pkg;

  localparam logic [3:0] OP_READY      = 4'b0001;
  localparam logic [3:0] OP_SUSPEND    = 4'b0010;
  localparam logic [3:0] OP_WAIT       = 4'b0011;
  localparam logic [3:0] OP_KILL       = 4'b0100;
  localparam logic [3:0] OP_SET_PRIO   = 4'b0101;
  localparam logic [3:0] OP_SET_EXEHIT = 4'b0110;
  localparam logic [3:0] OP_EXECUTE    = 4'b0111;
  localparam logic [3:0] OP_FINISH     = 4'b1111;

  localparam int CMD_W       = 16;
  localparam int FIELD_W     = 4;
  localparam int CMD_ARG_LSB = 0;
  localparam int CMD_OP_LSB  = 4;
  localparam int CMD_ID_LSB  = 8;

  localparam int SORT_W        = 8;
  localparam int SORT_PRIO_LSB = 0;
  localparam int SORT_ID_LSB   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } disp_state_e;

  function automatic logic [CMD_W-1:0] make_cmd(input logic [FIELD_W-1:0] id,
                                                input logic [FIELD_W-1:0] op,
                                                input logic [FIELD_W-1:0] arg);
    logic [CMD_W-1:0] w;
    w = '0;
    w[CMD_ID_LSB  +: FIELD_W] = id;
    w[CMD_OP_LSB  +: FIELD_W] = op;
    w[CMD_ARG_LSB +: FIELD_W] = arg;
    return w;
  endfunction

  // Host commands that end the running task's slice early.
  function automatic logic is_preempt_op(input logic [FIELD_W-1:0] op);
    return (op == OP_SUSPEND) || (op == OP_WAIT) || (op == OP_KILL);
  endfunction

  // Execute/Finish belong to the scheduler alone; the host may not inject them.
  function automatic logic is_sched_op(input logic [FIELD_W-1:0] op);
    return (op == OP_EXECUTE) || (op == OP_FINISH);
  endfunction

endpackage

// File: rtl/priority_select.sv
// -----------------------------------------------------------------------------
// priority_select
// Combinational argmax over N_TASKS ready tasks.
//
// Ports:
//   i_ready  [N_TASKS]    : per-task ready flag
//   i_prio   [4*N_TASKS]  : packed 4-bit priorities, slice i = task i
//   i_start  [4]          : first index of the search (round-robin mode only)
//   o_winner [4]          : index of the highest-priority ready task
//   o_found  [1]          : at least one task is ready
//
// Build option: DISPATCH_RR_EN defined -> equal priorities resolve to the first
// ready task found scanning upward (with wrap) from i_start; undefined -> the
// lowest index wins and i_start is ignored.
// -----------------------------------------------------------------------------
module priority_select
  import task_bus_pkg::*;
#(
  parameter int N_TASKS = 8
) (
  input  logic [N_TASKS-1:0]         i_ready,
  input  logic [FIELD_W*N_TASKS-1:0] i_prio,
  input  logic [FIELD_W-1:0]         i_start,
  output logic [FIELD_W-1:0]         o_winner,
  output logic                       o_found
);

  localparam int IDX_W = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;

  logic [FIELD_W-1:0] w_prio_a [N_TASKS];
  int                 w_base;

  always_comb begin
    for (int i = 0; i < N_TASKS; i++) begin
      w_prio_a[i] = i_prio[FIELD_W*i +: FIELD_W];
    end
  end

`ifdef DISPATCH_RR_EN
  assign w_base = (int'(i_start) < N_TASKS) ? int'(i_start) : 0;
`else
  logic w_unused_start;
  assign w_unused_start = ^i_start;
  assign w_base         = 0;
`endif

  // Strict '>' keeps the first candidate in scan order on a tie, so the scan
  // origin alone decides the tie-break policy.
  always_comb begin
    logic [FIELD_W-1:0] best;
    logic [IDX_W-1:0]   idx;
    int                 t;
    o_winner = '0;
    o_found  = 1'b0;
    best     = '0;
    for (int k = 0; k < N_TASKS; k++) begin
      t = w_base + k;
      if (t >= N_TASKS) t = t - N_TASKS;
      idx = IDX_W'(t);
      if (i_ready[idx] && (!o_found || (w_prio_a[idx] > best))) begin
        o_found  = 1'b1;
        best     = w_prio_a[idx];
        o_winner = FIELD_W'(t);
      end
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// -----------------------------------------------------------------------------
// task_dispatcher
// Central scheduler on the 16-bit task command bus. Picks the highest-priority
// ready task from the sorter words, issues Execute, lets it run for a fixed
// slice, issues Finish, and forwards host-injected commands in between.
//
// Ports:
//   CLK, RST        : clock, asynchronous active-high reset
//   sorter_in       : N_TASKS packed {id, prio} words; slice i ready iff it is
//                     non-zero and its id field equals i
//   host_op         : host command {4'b0, id, opcode, arg}
//   host_valid      : host command present
//   host_ready      : host command taken when high together with host_valid
//   op_out          : command bus, 16'h0000 when idle
//   op_valid        : op_out is non-zero
//   cur_task        : id of the task holding the slice (valid while busy)
//   busy            : high in EXEC, RUN and FINISH
//
// Build option: DISPATCH_RR_EN selects round-robin tie-breaking (search starts
// one past the last dispatched task); default is lowest-index-wins.
// -----------------------------------------------------------------------------
module task_dispatcher
  import task_bus_pkg::*;
#(
  parameter int N_TASKS      = 8,
  parameter int SLICE_CYCLES = 10000
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [SORT_W*N_TASKS-1:0] sorter_in,
  input  logic [CMD_W-1:0]          host_op,
  input  logic                      host_valid,
  output logic                      host_ready,
  output logic [CMD_W-1:0]          op_out,
  output logic                      op_valid,
  output logic [FIELD_W-1:0]        cur_task,
  output logic                      busy
);

  localparam int               CNT_W    = $clog2(SLICE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE_CYCLES - 1);

  disp_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_host_ready;
  logic                 r_busy;
  logic [FIELD_W-1:0]   r_cur_task;
  logic [CMD_W-1:0]     r_op_out;
  logic                 r_op_valid;

  logic [N_TASKS-1:0]         w_ready;
  logic [FIELD_W*N_TASKS-1:0] w_prio;
  logic [FIELD_W-1:0]         w_start;
  logic [FIELD_W-1:0]         w_winner;
  logic                       w_found;
  logic                       w_host_acc;
  logic                       w_host_fwd;
  logic                       w_host_preempt;
  logic [FIELD_W-1:0]         w_host_opc;
  logic [FIELD_W-1:0]         w_host_id;
  logic [CMD_W-1:0]           w_op_nxt;

  assign host_ready = r_host_ready;
  assign op_out     = r_op_out;
  assign op_valid   = r_op_valid;
  assign cur_task   = r_cur_task;
  assign busy       = r_busy;

  always_comb begin
    w_ready = '0;
    w_prio  = '0;
    for (int i = 0; i < N_TASKS; i++) begin
      w_prio[FIELD_W*i +: FIELD_W] = sorter_in[SORT_W*i + SORT_PRIO_LSB +: FIELD_W];
      w_ready[i] = (sorter_in[SORT_W*i +: SORT_W] != '0) &&
                   (sorter_in[SORT_W*i + SORT_ID_LSB +: FIELD_W] == FIELD_W'(i));
    end
  end

`ifdef DISPATCH_RR_EN
  logic [FIELD_W-1:0] r_rr_last;

  assign w_start = (r_rr_last == FIELD_W'(N_TASKS - 1)) ? '0 : r_rr_last + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr_last <= '0;
    end else if (r_state == ST_EXEC) begin
      r_rr_last <= r_cur_task;
    end
  end
`else
  assign w_start = '0;
`endif

  priority_select #(
    .N_TASKS (N_TASKS)
  ) u_sel (
    .i_ready  (w_ready),
    .i_prio   (w_prio),
    .i_start  (w_start),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  assign w_host_opc     = host_op[CMD_OP_LSB +: FIELD_W];
  assign w_host_id      = host_op[CMD_ID_LSB +: FIELD_W];
  assign w_host_acc     = host_valid && r_host_ready;
  assign w_host_fwd     = w_host_acc && !is_sched_op(w_host_opc);
  assign w_host_preempt = w_host_acc && (r_state == ST_RUN) &&
                          is_preempt_op(w_host_opc) && (w_host_id == r_cur_task);

  // host_ready is held low on the final RUN cycle, so a forwarded host word
  // and the Finish word can never compete for the same bus cycle.
  always_comb begin
    w_op_nxt = '0;
    case (r_state)
      ST_IDLE:   if (w_host_fwd) w_op_nxt = host_op;
      ST_SELECT: if (w_found)    w_op_nxt = make_cmd(w_winner, OP_EXECUTE, 4'h0);
      ST_RUN: begin
        if (w_host_fwd)              w_op_nxt = host_op;
        else if (r_cnt == CNT_LAST)  w_op_nxt = make_cmd(r_cur_task, OP_FINISH, 4'h0);
      end
      default:   w_op_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_host_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_cur_task   <= '0;
      r_op_out     <= '0;
      r_op_valid   <= 1'b0;
    end else begin
      r_op_out   <= w_op_nxt;
      r_op_valid <= (w_op_nxt != '0);
      case (r_state)
        ST_IDLE: begin
          // An accepted host command (even a dropped one) defers selection.
          if (!w_host_acc && (|w_ready)) begin
            r_state      <= ST_SELECT;
            r_host_ready <= 1'b0;
          end else begin
            r_host_ready <= 1'b1;
          end
        end
        ST_SELECT: begin
          if (w_found) begin
            r_state    <= ST_EXEC;
            r_cur_task <= w_winner;
            r_busy     <= 1'b1;
          end else begin
            r_state      <= ST_IDLE;
            r_host_ready <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_state      <= ST_RUN;
          r_cnt        <= '0;
          r_host_ready <= 1'b1;
        end
        ST_RUN: begin
          if (w_host_preempt) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_host_ready <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_state      <= ST_FINISH;
            r_host_ready <= 1'b0;
          end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_host_ready <= ((r_cnt + 1'b1) != CNT_LAST);
          end
        end
        ST_FINISH: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_host_ready <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_host_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_task_dispatcher
// Directed stimulus with a scoreboard: every expected bus word is queued with
// the clock cycle it must appear in; a monitor branch pops and compares each
// non-zero bus word as it is observed.
// -----------------------------------------------------------------------------
module tb_task_dispatcher;

  localparam int S = 6;
  localparam int N = 8;

  logic          CLK;
  logic          RST;
  logic [8*N-1:0] sorter;
  logic [15:0]   host_op;
  logic          host_valid;
  logic          host_ready;
  logic [15:0]   op_out;
  logic          op_valid;
  logic [3:0]    cur_task;
  logic          busy;

  int cyc;
  int n_checks;
  int n_errors;

  typedef struct {
    logic [15:0] w;
    int          c;
  } exp_t;

  exp_t q[$];

  task_dispatcher #(
    .N_TASKS      (N),
    .SLICE_CYCLES (S)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .sorter_in  (sorter),
    .host_op    (host_op),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .op_out     (op_out),
    .op_valid   (op_valid),
    .cur_task   (cur_task),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic expect_op(input logic [15:0] w, input int c);
    exp_t e;
    e.w = w;
    e.c = c;
    q.push_back(e);
  endtask

  function automatic logic [8*N-1:0] slot(input int i, input logic [7:0] v);
    logic [8*N-1:0] r;
    r = (8*N)'(v);
    return r << (8 * i);
  endfunction

  // Present s in an IDLE cycle, expect Execute/Finish for task id, clear the
  // sorter once the slice is running and wait until the FSM is idle again.
  task automatic dispatch(input string name, input logic [8*N-1:0] s, input logic [3:0] id);
    int c;
    c      = cyc;
    sorter = s;
    expect_op({4'h0, id, 4'h7, 4'h0}, c + 2);
    expect_op({4'h0, id, 4'hF, 4'h0}, c + 3 + S);
    tick(4);
    chk({name, " busy"}, 32'(busy), 32'd1);
    chk({name, " cur_task"}, 32'(cur_task), 32'(id));
    sorter = '0;
    tick(S + 4);
    chk({name, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    RST        = 1'b1;
    sorter     = '0;
    host_op    = '0;
    host_valid = 1'b0;

    fork
      begin : monitor
        forever begin
          @(negedge CLK);
          if (!RST && (op_valid || (op_out != 16'h0000))) begin
            if (q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected op: got %h at cycle %0d, expected none", op_out, cyc);
            end else begin
              exp_t e;
              e = q.pop_front();
              chk("op word", 32'(op_out), 32'(e.w));
              chk("op cycle", cyc, e.c);
              chk("op_valid", 32'(op_valid), 32'd1);
            end
          end
        end
      end
      begin : stimulus
        int c;
        logic [3:0] second;

        // Reset values
        tick(3);
        chk("reset op_out", 32'(op_out), 32'd0);
        chk("reset op_valid", 32'(op_valid), 32'd0);
        chk("reset host_ready", 32'(host_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset cur_task", 32'(cur_task), 32'd0);
        RST = 1'b0;
        chk("host_ready at release", 32'(host_ready), 32'd0);
        tick(1);
        chk("host_ready first clock", 32'(host_ready), 32'd1);
        tick(2);

        // Tie-break: tasks 1 and 6 at priority 7 over two slices
`ifdef DISPATCH_RR_EN
        second = 4'd6;
`else
        second = 4'd1;
`endif
        c      = cyc;
        sorter = slot(1, 8'h17) | slot(6, 8'h67);
        expect_op(16'h0170, c + 2);
        expect_op(16'h01F0, c + 3 + S);
        expect_op({4'h0, second, 4'h7, 4'h0}, c + S + 6);
        expect_op({4'h0, second, 4'hF, 4'h0}, c + 2 * S + 7);
        tick(4);
        chk("tie first cur_task", 32'(cur_task), 32'd1);
        tick(S + 3);
        chk("tie second cur_task", 32'(cur_task), 32'(second));
        sorter = '0;
        tick(S + 4);
        chk("tie idle", 32'(busy), 32'd0);

        // Single ready task, and max priority
        dispatch("rotate", slot(3, 8'h35), 4'd3);
        dispatch("maxprio", slot(2, 8'h24) | slot(5, 8'h59), 4'd5);

        // Slot whose id field does not match its index is not ready
        sorter = slot(2, 8'h35);
        tick(5);
        chk("id mismatch busy", 32'(busy), 32'd0);
        sorter = '0;
        tick(2);

        // Host preemption: Kill task 3 while it runs
        c      = cyc;
        sorter = slot(3, 8'h35);
        expect_op(16'h0370, c + 2);
        tick(4);
        sorter = '0;
        chk("preempt busy before", 32'(busy), 32'd1);
        chk("preempt host_ready in run", 32'(host_ready), 32'd1);
        host_op    = 16'h0340;
        host_valid = 1'b1;
        expect_op(16'h0340, c + 5);
        tick(1);
        host_valid = 1'b0;
        chk("preempt busy drops", 32'(busy), 32'd0);
        tick(S + 4);

        // Host filter: Execute from the host is dropped
        host_op    = 16'h0270;
        host_valid = 1'b1;
        tick(1);
        host_valid = 1'b0;
        tick(3);
        chk("filter busy", 32'(busy), 32'd0);

        // Host vs scheduler in IDLE, plus a non-preempting host word in RUN
        c          = cyc;
        host_op    = 16'h0255;
        host_valid = 1'b1;
        sorter     = slot(4, 8'h43);
        expect_op(16'h0255, c + 1);
        expect_op(16'h0470, c + 3);
        expect_op(16'h0512, c + 6);
        expect_op(16'h04F0, c + 4 + S);
        tick(1);
        host_valid = 1'b0;
        tick(3);
        sorter = '0;
        chk("contention cur_task", 32'(cur_task), 32'd4);
        tick(1);
        host_op    = 16'h0512;
        host_valid = 1'b1;
        tick(1);
        host_valid = 1'b0;
        chk("run forward keeps busy", 32'(busy), 32'd1);
        tick(S + 2);

        // Reset mid-RUN while a forwarded host word is on the bus
        c      = cyc;
        sorter = slot(3, 8'h35);
        expect_op(16'h0370, c + 2);
        tick(3);
        sorter = '0;
        tick(1);
        host_op    = 16'h0512;
        host_valid = 1'b1;
        tick(1);
        host_valid = 1'b0;
        chk("pre-reset bus word", 32'(op_out), 32'h0512);
        RST = 1'b1;
        #1;
        chk("async reset op_out", 32'(op_out), 32'd0);
        chk("async reset op_valid", 32'(op_valid), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        tick(2);
        c      = cyc;
        sorter = slot(3, 8'h35);
        RST    = 1'b0;
        expect_op(16'h0370, c + 2);
        expect_op(16'h03F0, c + 3 + S);
        tick(3);
        sorter = '0;
        tick(S + 4);
        chk("post-reset idle", 32'(busy), 32'd0);
      end
    join_any

    chk("pending expected ops", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/task_dispatcher.md
# task_dispatcher

Central scheduler that drives the 16-bit task command bus: it collects the `{id, priority}` sorter words published by up to N task modules and selects the highest-priority ready task. It issues Execute and Finish commands for a fixed time slice and forwards host-injected state-change commands. It is the initiating end of the command bus that every task module decodes, and the consuming end of their sorter outputs.

## Interface
- `N_TASKS`, default 8: number of sorter inputs; task IDs are 0..N_TASKS-1, maximum 16.
- `SLICE_CYCLES`, default 10000: RUN-state length in clock cycles; minimum 2.
- `CLK`, in, 1: clock.
- `RST`, in, 1: reset, asynchronous, active-high.
- `sorter_in`, in, 8*N_TASKS: packed sorter words; slice i = `{id[3:0], prio[3:0]}`; all-zero means task not ready.
- `host_op`, in, 16: host command word `{4'b0, id[3:0], opcode[3:0], arg[3:0]}`.
- `host_valid`, in, 1: host command present.
- `host_ready`, out, 1: host command accepted this cycle when high together with `host_valid`.
- `op_out`, out, 16: command bus to all tasks; 16'h0000 when no command is driven.
- `op_valid`, out, 1: high exactly when `op_out` is non-zero.
- `cur_task`, out, 4: ID of the running task; valid while `busy`.
- `busy`, out, 1: high in EXEC, RUN and FINISH.

## Operation
- Opcodes: 0001 Ready, 0010 Suspend, 0011 Wait, 0100 Kill, 0101 Set priority, 0110 Set exe-hit, 0111 Execute, 1111 Finish.
- Ready qualification: slice i is ready iff it is non-zero and its id field equals i. A mismatched ID is treated as not ready.
- FSM states and transitions:
  - IDLE → SELECT when any task is ready and no host command is accepted this cycle.
  - SELECT: registers the winner, which is the maximum `prio`. Tie-break is set by the configuration. If the winner has dropped to not ready, return to IDLE.
  - EXEC: drives `{4'b0, id, 4'b0111, 4'b0}` for exactly 1 cycle, then RUN.
  - RUN: counts SLICE_CYCLES cycles, then FINISH.
  - FINISH: drives `{4'b0, id, 4'b1111, 4'b0}` for exactly 1 cycle, then IDLE.
- Host path: `host_ready` = 1 in IDLE and RUN, 0 in SELECT, EXEC and FINISH. An accepted host command is driven on `op_out` for exactly 1 cycle, starting the cycle after acceptance.
- Host preemption: in RUN, an accepted Suspend, Wait or Kill whose id equals `cur_task` is forwarded, then the FSM goes to IDLE with no Finish issued.
- Host opcode filter: opcodes 0111 and 1111 from the host are accepted and dropped; they are never forwarded.
- Host vs scheduler in IDLE: when both want the bus, the host wins; selection waits.
- Pulse discipline: `op_out` returns to 16'h0000 after every command, because tasks act on any non-zero word each cycle.
- Slice counter: unsigned, width `$clog2(SLICE_CYCLES+1)`, cleared on entry to RUN, no wrap.

## Timing
- Reset values: `op_out`=0, `op_valid`=0, `host_ready`=0, `busy`=0, `cur_task`=0, state IDLE, counter 0, round-robin pointer 0.
- `host_ready` goes to 1 on the first clock after RST deasserts.
- Reset mid-command: `op_out` clears asynchronously and no partial command is reissued.
- Selection latency: ready seen in IDLE at cycle t → SELECT at t+1 → Execute on the bus at t+2.
- Command spacing: Execute at cycle e → Finish at e+1+SLICE_CYCLES → earliest next Execute at e+SLICE_CYCLES+4.
- Sorter inputs are sampled only in IDLE and SELECT; changes during RUN are ignored.

## Configuration
- `DISPATCH_RR_EN` defined: ties are broken round-robin. Search starts at index (last dispatched + 1) mod N_TASKS. The pointer updates on each EXEC.
- `DISPATCH_RR_EN` undefined: ties are won by the lowest index and no pointer is kept.

## Structure
- Shared package `task_bus_pkg`: opcode localparams (OP_READY … OP_FINISH), the bit-field positions of the command word, the sorter word layout, and FSM state encoding.
- Sub-module `priority_select`: combinational argmax over N_TASKS. Inputs are the ready vector, the priority array and the start index. Outputs are winner index and found flag. The tie-break mode is applied inside it.

## Test plan
- Rotate ready: task 3 = 8'h35, all others 0 → `op_out`=16'h0370 one cycle, then 16'h03F0 exactly SLICE_CYCLES+1 cycles later.
- Max priority: task 2 = 8'h24, task 5 = 8'h59 → task 5 dispatched, Execute 16'h0570.
- Tie-break: tasks 1 and 6 both priority 7, two consecutive slices. With `DISPATCH_RR_EN`: 1 then 6. Without: 1 then 1.
- Host preemption: host 16'h0340 (Kill task 3) during RUN of task 3 → 16'h0340 forwarded, no 16'h03F0, `busy` drops next cycle.
- Host filter and contention: host 16'h0270 → dropped, never on the bus. Host 16'h0255 in IDLE while task 4 is ready → 16'h0255 first, then 16'h0470.
- Reset mid-RUN: assert RST → `op_out`=0 and `busy`=0 immediately. After release, first Execute appears 2 cycles after IDLE sees a ready task.
